xi1_min_search: RTL and testbench

Downstream consumer of the `xI1_cal` stream in the SOML decoder. Accepts a block of `NCAND` candidate `xI1` values (signed fixed-point), hard-slices each to the nearest PAM-4 level, computes squared slicing error, and tracks the candidate with minimum error. Once per block it emits the winning index, its PAM-4 symbol and its error metric over a valid/ready handshake. The result feeds the final symbol-decision stage.

---
 rtl/soml_pkg.sv | 43 ++++
 rtl/xi1_min_search_slicer.sv | 44 ++++
 rtl/xi1_min_search.sv | 178 +++++++++++++++++
 tb/tb_xi1_min_search.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soml_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soml_pkg
//  Description : Shared SOML decoder definitions: datapath defaults, PAM-4
//                slicing thresholds and levels (Q7.8), symbol encoding and
//                the min-search FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package soml_pkg;

    // Datapath defaults for the xI1 stream (Q7.8, signed)
    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 8;
    localparam int ERRW     = DW_DEF + 1;

    // Slicing thresholds in Q7.8
    localparam logic signed [ERRW-1:0] THR_NEG  = -17'sd512;
    localparam logic signed [ERRW-1:0] THR_ZERO =  17'sd0;
    localparam logic signed [ERRW-1:0] THR_POS  =  17'sd512;

    // PAM-4 reconstruction levels in Q7.8
    localparam logic signed [ERRW-1:0] LVL_M3 = -17'sd768;
    localparam logic signed [ERRW-1:0] LVL_M1 = -17'sd256;
    localparam logic signed [ERRW-1:0] LVL_P1 =  17'sd256;
    localparam logic signed [ERRW-1:0] LVL_P3 =  17'sd768;

    // Symbol encoding: 0=-3, 1=-1, 2=+1, 3=+3
    typedef enum logic [1:0] {
        SYM_M3 = 2'd0,
        SYM_M1 = 2'd1,
        SYM_P1 = 2'd2,
        SYM_P3 = 2'd3
    } pam4_sym_t;

    // Block-level control of the min search
    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage : soml_pkg
`default_nettype wire

// File: rtl/xi1_min_search_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : pam4_slicer
//  Description : Combinational hard slicer. Maps a Q7.8 sample to the nearest
//                PAM-4 level and returns the symbol and the signed slicing
//                error (sample minus level), one bit wider than the input.
//  Revision    : 1.0  initial release
// ============================================================================
module pam4_slicer
    import soml_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0]        in_xI1,
    output logic [1:0]           sym,
    output logic signed [DW:0]   err
);

    logic signed [DW:0] x_ext;
    logic signed [DW:0] level;

    // Sign-extend so the error cannot overflow for any input
    assign x_ext = $signed({in_xI1[DW-1], in_xI1});

    // Decide the nearest level; boundaries belong to the upper region
    always_comb begin
        sym   = SYM_P1;
        level = LVL_P1;
        if (x_ext < THR_NEG) begin
            sym   = SYM_M3;
            level = LVL_M3;
        end else if (x_ext < THR_ZERO) begin
            sym   = SYM_M1;
            level = LVL_M1;
        end else if (x_ext >= THR_POS) begin
            sym   = SYM_P3;
            level = LVL_P3;
        end
    end

    assign err = x_ext - level;

endmodule : pam4_slicer
`default_nettype wire

// File: rtl/xi1_min_search.sv
`default_nettype none
// ============================================================================
//  Module      : xi1_min_search
//  Description : Slices a block of NCAND xI1 candidates to PAM-4, squares the
//                slicing error and reports the lowest-error candidate (index,
//                symbol, error) once per block over a valid/ready handshake.
//                Pipeline: S1 slice/error, S2 square, S3 tracker update.
//  Revision    : 1.0  initial release
// ============================================================================
module xi1_min_search
    import soml_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int NCAND = 16,
    parameter int IDXW  = 4
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_xI1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_idx,
    output logic [1:0]        out_sym,
    output logic [31:0]       out_err
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCAND - 1);
    // Levels and thresholds come from the package and assume Q.8 scaling
    localparam int FRAC_CHK = FRAC;

    state_t state, state_nxt;

    logic [IDXW-1:0]    cnt;
    logic               accept;
    logic               last_in;

    logic [1:0]         slc_sym;
    logic signed [DW:0] slc_err;

    logic               s1_valid, s1_last;
    logic [IDXW-1:0]    s1_idx;
    logic [1:0]         s1_sym;
    logic signed [DW:0] s1_err;
    logic signed [31:0] s1_err_ext;

    logic               s2_valid, s2_last;
    logic [IDXW-1:0]    s2_idx;
    logic [1:0]         s2_sym;
    logic [31:0]        s2_sq;

    logic               s3_last;
    logic [IDXW-1:0]    trk_idx;
    logic [1:0]         trk_sym;
    logic [31:0]        trk_err;

    logic               load_out;

    assign in_ready  = (state == ST_ACCEPT);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign last_in   = (cnt == LAST_IDX) && (FRAC_CHK >= 0);
    assign load_out  = (state == ST_DRAIN) && s3_last;

    pam4_slicer #(
        .DW (DW)
    ) u_slicer (
        .in_xI1 (in_xI1),
        .sym    (slc_sym),
        .err    (slc_err)
    );

    // Arrival-order index of the next accepted candidate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if ((state == ST_HOLD) && out_ready) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= last_in ? '0 : cnt + IDXW'(1);
        end
    end

    // S1: register slicer result with its index and end-of-block tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
            s1_sym   <= '0;
            s1_err   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= last_in;
                s1_idx  <= cnt;
                s1_sym  <= slc_sym;
                s1_err  <= slc_err;
            end
        end
    end

    // |e| <= 33536 so the square stays below 2^31 and a 32-bit product is exact
    assign s1_err_ext = 32'(s1_err);

    // S2: square the error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_idx   <= '0;
            s2_sym   <= '0;
            s2_sq    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_idx  <= s1_idx;
                s2_sym  <= s1_sym;
                s2_sq   <= s1_err_ext * s1_err_ext;
            end
        end
    end

    // S3: index 0 always seeds the tracker; strict less-than keeps the lowest index on ties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_last <= 1'b0;
            trk_idx <= '0;
            trk_sym <= '0;
            trk_err <= '0;
        end else begin
            s3_last <= s2_valid && s2_last;
            if (s2_valid && ((s2_idx == '0) || (s2_sq < trk_err))) begin
                trk_idx <= s2_idx;
                trk_sym <= s2_sym;
                trk_err <= s2_sq;
            end
        end
    end

    // Result registers capture the tracker once the block's last update has landed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_idx <= '0;
            out_sym <= '0;
            out_err <= '0;
        end else if (load_out) begin
            out_idx <= trk_idx;
            out_sym <= trk_sym;
            out_err <= trk_err;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCEPT: if (accept && last_in) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (s3_last)           state_nxt = ST_HOLD;
            ST_HOLD:   if (out_ready)         state_nxt = ST_ACCEPT;
            default:                          state_nxt = ST_ACCEPT;
        endcase
    end

endmodule : xi1_min_search
`default_nettype wire

// File: tb/tb_xi1_min_search.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_xi1_min_search
//  Description : Self-checking bench for xi1_min_search: slicer probe table,
//                directed blocks, back-pressure, reset mid-block and random
//                blocks against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xi1_min_search;

    localparam int DW    = 16;
    localparam int NCAND = 16;
    localparam int IDXW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_xI1;
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_idx;
    logic [1:0]      out_sym;
    logic [31:0]     out_err;

    int errors = 0;
    int checks = 0;
    int blk [NCAND];

    typedef struct {
        int x;
        int sym;
        int err;
    } slc_vec_t;

    slc_vec_t vt [8];

    always #5 clk = ~clk;

    xi1_min_search #(
        .DW    (DW),
        .FRAC  (8),
        .NCAND (NCAND),
        .IDXW  (IDXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_xI1    (in_xI1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_sym   (out_sym),
        .out_err   (out_err)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: nearest PAM-4 level in units of 1.0 (Q7.8 value / 256)
    function automatic int ref_level(input int x);
        if (x < -512) return -3;
        if (x < 0)    return -1;
        if (x < 512)  return 1;
        return 3;
    endfunction

    function automatic int ref_sym(input int x);
        return (ref_level(x) + 3) / 2;
    endfunction

    function automatic longint ref_sqerr(input int x);
        longint e;
        e = longint'(x) - longint'(ref_level(x)) * 256;
        return e * e;
    endfunction

    // Send blk[] with random gaps, then check latency, result, optional back-pressure
    task automatic run_block(input string tag, input int gap_pct, input int hold_cycles);
        int     acc, guard, lat, leak, unstable;
        bit     go;
        int     e_idx;
        longint e_err, ce;
        logic [IDXW-1:0] s_idx;
        logic [1:0]      s_sym;
        logic [31:0]     s_err;

        e_idx = 0;
        e_err = ref_sqerr(blk[0]);
        for (int i = 1; i < NCAND; i++) begin
            ce = ref_sqerr(blk[i]);
            if (ce < e_err) begin
                e_err = ce;
                e_idx = i;
            end
        end

        acc   = 0;
        guard = 0;
        while (acc < NCAND && guard < 400) begin
            @(negedge clk);
            guard++;
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                in_xI1   = DW'($urandom);
            end else begin
                in_valid = 1'b1;
                in_xI1   = DW'(blk[acc]);
            end
            go = in_valid && in_ready;
            @(posedge clk);
            if (go) acc++;
        end
        check({tag, " accepted"}, acc, NCAND);

        // Keep offering data while draining: none of it may be taken
        lat  = -1;
        leak = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_xI1   = DW'($urandom);
            if (in_ready) leak++;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, 3);
        check({tag, " ready_in_drain"}, leak, 0);
        check({tag, " idx"}, longint'(out_idx), e_idx);
        check({tag, " sym"}, longint'(out_sym), ref_sym(blk[e_idx]));
        check({tag, " err"}, longint'(out_err), e_err);

        if (hold_cycles > 0) begin
            s_idx    = out_idx;
            s_sym    = out_sym;
            s_err    = out_err;
            unstable = 0;
            leak     = 0;
            out_ready = 1'b0;
            for (int k = 0; k < hold_cycles; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_xI1   = DW'($urandom);
                if (in_ready) leak++;
                if (!out_valid || out_idx != s_idx || out_sym != s_sym || out_err != s_err)
                    unstable++;
            end
            check({tag, " hold_unstable"}, unstable, 0);
            check({tag, " hold_ready"}, leak, 0);
        end

        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid_after_accept"}, longint'(out_valid), 0);
        check({tag, " ready_after_accept"}, longint'(in_ready), 1);
    endtask

    task automatic fill_random();
        int lv [4];
        lv[0] = -768; lv[1] = -256; lv[2] = 256; lv[3] = 768;
        for (int i = 0; i < NCAND; i++) begin
            if ($urandom_range(0, 1) == 1)
                blk[i] = int'($urandom_range(0, 65535)) - 32768;
            else
                blk[i] = lv[$urandom_range(0, 3)] + int'($urandom_range(0, 4)) - 2;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, guard;
        bit go;

        vt[0] = '{x: -513,   sym: 0, err: 255};
        vt[1] = '{x: -512,   sym: 1, err: -256};
        vt[2] = '{x: -1,     sym: 1, err: 255};
        vt[3] = '{x: 0,      sym: 2, err: -256};
        vt[4] = '{x: 511,    sym: 2, err: 255};
        vt[5] = '{x: 512,    sym: 3, err: -256};
        vt[6] = '{x: -32768, sym: 0, err: -32000};
        vt[7] = '{x: 32767,  sym: 3, err: 31999};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_xI1    = '0;
        out_ready = 1'b0;

        #12;
        check("reset in_ready", longint'(in_ready), 1);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_idx", longint'(out_idx), 0);
        check("reset out_sym", longint'(out_sym), 0);
        check("reset out_err", longint'(out_err), 0);
        @(negedge clk);
        rst = 1'b1;

        // Slicer probe table (in_valid low so nothing is consumed)
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_xI1   = DW'(vt[i].x);
            #1;
            check($sformatf("slicer sym x=%0d", vt[i].x), longint'(dut.u_slicer.sym), vt[i].sym);
            check($sformatf("slicer err x=%0d", vt[i].x), longint'(dut.u_slicer.err), vt[i].err);
        end

        // All exact +1: every error zero, tie resolves to index 0
        for (int i = 0; i < NCAND; i++) blk[i] = 256;
        run_block("exact_p1", 0, 0);

        // One near -3 among values far from +1
        for (int i = 0; i < NCAND; i++) blk[i] = 100;
        blk[9] = -760;
        run_block("cand9", 0, 0);

        // Threshold values, rest far from any level
        for (int i = 0; i < NCAND; i++) blk[i] = 5000;
        blk[0] = -513; blk[1] = -512; blk[2] = -1;
        blk[3] = 0;    blk[4] = 511;  blk[5] = 512;
        run_block("thresholds", 0, 0);

        // Extremes
        for (int i = 0; i < NCAND; i++) blk[i] = 300;
        blk[5] = -32768;
        run_block("neg_extreme", 20, 0);
        for (int i = 0; i < NCAND; i++) blk[i] = 32767;
        run_block("pos_extreme", 0, 0);

        // Back-pressure for 10 cycles in HOLD
        fill_random();
        run_block("backpressure", 25, 10);

        // Random blocks with gaps
        for (int b = 0; b < 6; b++) begin
            fill_random();
            run_block($sformatf("random%0d", b), 30, (b % 2) * 3);
        end

        // Reset after candidate 7 of a block
        fill_random();
        acc   = 0;
        guard = 0;
        while (acc < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = ($urandom_range(0, 99) >= 30);
            in_xI1   = DW'(blk[acc]);
            go = in_valid && in_ready;
            @(posedge clk);
            if (go) acc++;
        end
        check("partial accepted", acc, 8);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst out_valid", longint'(out_valid), 0);
        check("midrst out_idx", longint'(out_idx), 0);
        check("midrst out_sym", longint'(out_sym), 0);
        check("midrst out_err", longint'(out_err), 0);
        check("midrst in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        fill_random();
        run_block("after_reset", 30, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_xi1_min_search
`default_nettype wire
